// File: rtl/soundgen_pkg.sv
// Shared constants and helpers for the soundgen tone core.
// The noise option is enabled with the SOUNDGEN_NOISE_EN macro.
package soundgen_pkg;

   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   // Right-shifting form of taps 16,14,13,11: feedback from bits 0,2,3,5 into bit 15.
   localparam logic [15:0] LFSR_TAPS = 16'h002D;

   function automatic int clog2_min1(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/soundgen_tone_core_if.sv
// Control/status bundle for soundgen_tone_core.
// noise_sel exists only when SOUNDGEN_NOISE_EN is defined.
interface soundgen_tone_core_if #(
   parameter int NUM_CH = 2,
   parameter int DIV_W  = 12
);
   import soundgen_pkg::*;

   localparam int CH_W  = clog2_min1(NUM_CH);
   localparam int MIX_W = $clog2(NUM_CH + 1);

   logic                ena;
   logic                wr_en;
   logic [CH_W-1:0]     wr_ch;
   logic [DIV_W-1:0]    wr_period;
   logic [NUM_CH-1:0]   ch_en;
`ifdef SOUNDGEN_NOISE_EN
   logic [NUM_CH-1:0]   noise_sel;
`endif
   logic [NUM_CH-1:0]   tone_out;
   logic [MIX_W-1:0]    mix_out;

   modport master (
      output ena, wr_en, wr_ch, wr_period, ch_en,
`ifdef SOUNDGEN_NOISE_EN
      output noise_sel,
`endif
      input  tone_out, mix_out
   );

   modport slave (
      input  ena, wr_en, wr_ch, wr_period, ch_en,
`ifdef SOUNDGEN_NOISE_EN
      input  noise_sel,
`endif
      output tone_out, mix_out
   );

endinterface

// File: rtl/soundgen_tone_ch.sv
// One tone channel: period register, down-counter and square-wave output.
// With SOUNDGEN_NOISE_EN the toggle event may load a noise bit instead.
module soundgen_tone_ch #(
   parameter int DIV_W = 12
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ena_i,
   input  logic             tick_i,
   input  logic             wr_hit_i,
   input  logic [DIV_W-1:0] wr_period_i,
   input  logic             ch_en_i,
`ifdef SOUNDGEN_NOISE_EN
   input  logic             noise_sel_i,
   input  logic             noise_bit_i,
   output logic             toggle_o,
`endif
   output logic             tone_o
);

   logic [DIV_W-1:0] period_q, period_d;
   logic [DIV_W-1:0] count_q, count_d;
   logic             tone_q, tone_d;

   always_comb begin
      period_d = period_q;
      count_d  = count_q;
      tone_d   = tone_q;
`ifdef SOUNDGEN_NOISE_EN
      toggle_o = 1'b0;
`endif
      if (wr_hit_i) begin
         // A write restarts the phase and overrides any same-cycle tick.
         period_d = wr_period_i;
         count_d  = wr_period_i;
         tone_d   = 1'b0;
      end else if (ena_i && (!ch_en_i || period_q == '0)) begin
         count_d = '0;
         tone_d  = 1'b0;
      end else if (tick_i) begin
         if (count_q == '0) begin
            count_d = period_q;
`ifdef SOUNDGEN_NOISE_EN
            toggle_o = 1'b1;
            tone_d   = noise_sel_i ? noise_bit_i : ~tone_q;
`else
            tone_d   = ~tone_q;
`endif
         end else begin
            count_d = count_q - 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         period_q <= '0;
         count_q  <= '0;
         tone_q   <= 1'b0;
      end else begin
         period_q <= period_d;
         count_q  <= count_d;
         tone_q   <= tone_d;
      end
   end

   assign tone_o = tone_q;

endmodule

// File: rtl/soundgen_tone_core.sv
// Multi-channel square-wave tone generator: shared prescaler, per-channel dividers, popcount mix.
// SOUNDGEN_NOISE_EN adds a shared LFSR and per-channel noise_sel.
module soundgen_tone_core
   import soundgen_pkg::*;
#(
   parameter int NUM_CH   = 2,
   parameter int DIV_W    = 12,
   parameter int PRESCALE = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   soundgen_tone_core_if.slave  bus
);

   localparam int CH_W  = clog2_min1(NUM_CH);
   localparam int PS_W  = $clog2(PRESCALE);
   localparam int MIX_W = $clog2(NUM_CH + 1);

   logic [PS_W-1:0]   presc_q, presc_d;
   logic              tick;
   logic [NUM_CH-1:0] tone_vec;
   logic [MIX_W-1:0]  mix;

   always_comb begin
      tick    = bus.ena && (presc_q == PS_W'(PRESCALE - 1));
      presc_d = presc_q;
      if (bus.ena) begin
         presc_d = tick ? '0 : presc_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc_q <= '0;
      end else begin
         presc_q <= presc_d;
      end
   end

`ifdef SOUNDGEN_NOISE_EN
   logic [NUM_CH-1:0] toggle_vec;
   logic [15:0]       lfsr_q, lfsr_d;

   // Toggle events only occur while ena is high, so the LFSR freezes with ena.
   always_comb begin
      lfsr_d = lfsr_q;
      if (|(toggle_vec & bus.noise_sel)) begin
         lfsr_d = {^(lfsr_q & LFSR_TAPS), lfsr_q[15:1]};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lfsr_q <= LFSR_SEED;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end
`endif

   generate
      for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
         logic wr_hit;
         assign wr_hit = bus.wr_en && (bus.wr_ch == CH_W'(gi));

         soundgen_tone_ch #(
            .DIV_W (DIV_W)
         ) u_ch (
            .clk         (clk),
            .rst_n       (rst_n),
            .ena_i       (bus.ena),
            .tick_i      (tick),
            .wr_hit_i    (wr_hit),
            .wr_period_i (bus.wr_period),
            .ch_en_i     (bus.ch_en[gi]),
`ifdef SOUNDGEN_NOISE_EN
            .noise_sel_i (bus.noise_sel[gi]),
            .noise_bit_i (lfsr_q[0]),
            .toggle_o    (toggle_vec[gi]),
`endif
            .tone_o      (tone_vec[gi])
         );
      end
   endgenerate

   always_comb begin
      mix = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         mix = mix + MIX_W'(tone_vec[i]);
      end
   end

   assign bus.tone_out = tone_vec;
   assign bus.mix_out  = mix;

endmodule
